// File: rtl/fetch_decode_hazard_if.sv
// Fetch/decode boundary bus: fetch inputs, decode-stage outputs, and the
// execute-stage feedback needed for load-use and redirect handling.
interface fetch_decode_hazard_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    // Fetch side
    logic [XLEN-1:0]  in_instr;
    logic [XLEN-1:0]  in_PC;
    logic [XLEN-1:0]  in_nextPC;
    logic             in_hlt;

    // Decode-stage register sources and execute-stage feedback
    logic [REG_W-1:0] dec_read_reg1;
    logic [REG_W-1:0] dec_read_reg2;
    logic             ex_mem_reg;
    logic             ex_reg_write;
    logic [REG_W-1:0] ex_write_reg;
    logic             ex_redirect;

    // Decode-stage register contents
    logic [XLEN-1:0]  out_instr;
    logic [XLEN-1:0]  out_PC;
    logic [XLEN-1:0]  out_nextPC;
    logic             out_valid;
    logic             out_hlt;

    // Pipeline control and status
    logic             stall_pc;
    logic             bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output in_instr, in_PC, in_nextPC, in_hlt,
        output dec_read_reg1, dec_read_reg2,
        output ex_mem_reg, ex_reg_write, ex_write_reg, ex_redirect,
        input  out_instr, out_PC, out_nextPC, out_valid, out_hlt,
        input  stall_pc, bubble, halted, stall_count
    );

    modport slave (
        input  in_instr, in_PC, in_nextPC, in_hlt,
        input  dec_read_reg1, dec_read_reg2,
        input  ex_mem_reg, ex_reg_write, ex_write_reg, ex_redirect,
        output out_instr, out_PC, out_nextPC, out_valid, out_hlt,
        output stall_pc, bubble, halted, stall_count
    );
endinterface

// File: rtl/fetch_decode_hazard.sv
// Fetch/decode pipeline register with load-use hazard detection, redirect
// flush, halt handling and a saturating stall counter.
module fetch_decode_hazard (
    input  logic                 clk,
    input  logic                 rst,
    fetch_decode_hazard_if.slave bus
);
    localparam int unsigned      XLEN      = 32;
    localparam int unsigned      CNT_W     = 16;
    localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [XLEN-1:0]  r_instr;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_npc;
    logic             r_valid;
    logic             r_hlt;
    logic [CNT_W-1:0] r_stall_count;
    logic [XLEN-1:0]  w_instr_nxt;
    logic [XLEN-1:0]  w_pc_nxt;
    logic [XLEN-1:0]  w_npc_nxt;
    logic             w_valid_nxt;
    logic             w_hlt_nxt;
    logic [CNT_W-1:0] w_stall_count_nxt;
    logic             w_hazard;
    logic             w_stall_pc;
    logic             w_bubble;

    // Load in execute writing a register the decode instruction reads; x0 never conflicts
    always_comb begin
        w_hazard = r_valid && bus.ex_mem_reg && bus.ex_reg_write &&
                   (bus.ex_write_reg != '0) &&
                   ((bus.ex_write_reg == bus.dec_read_reg1) ||
                    (bus.ex_write_reg == bus.dec_read_reg2));
    end

    // Next-state and control: redirect > halt entry > hazard > normal load
    always_comb begin
        w_state_nxt       = r_state;
        w_instr_nxt       = r_instr;
        w_pc_nxt          = r_pc;
        w_npc_nxt         = r_npc;
        w_valid_nxt       = r_valid;
        w_hlt_nxt         = r_hlt;
        w_stall_count_nxt = r_stall_count;
        w_stall_pc        = 1'b0;
        w_bubble          = 1'b1;

        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (bus.ex_redirect) begin
                        // Flush the wrong-path instruction; PCs keep their old values
                        w_instr_nxt = NOP_INSTR;
                        w_valid_nxt = 1'b0;
                        w_hlt_nxt   = 1'b0;
                    end else if (r_valid && r_hlt) begin
                        w_state_nxt = ST_HALTED;
                        w_stall_pc  = 1'b1;
                    end else if (w_hazard) begin
                        // One stall cycle: the load drains while a bubble enters execute
                        w_stall_pc = 1'b1;
                        if (r_stall_count != CNT_MAX) begin
                            w_stall_count_nxt = r_stall_count + CNT_W'(1);
                        end
                    end else begin
                        w_instr_nxt = bus.in_instr;
                        w_pc_nxt    = bus.in_PC;
                        w_npc_nxt   = bus.in_nextPC;
                        w_hlt_nxt   = bus.in_hlt;
                        w_valid_nxt = 1'b1;
                        w_bubble    = !r_valid;
                    end
                end
                ST_HALTED: begin
                    w_stall_pc = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_instr       <= NOP_INSTR;
            r_pc          <= '0;
            r_npc         <= '0;
            r_valid       <= 1'b0;
            r_hlt         <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_instr       <= w_instr_nxt;
            r_pc          <= w_pc_nxt;
            r_npc         <= w_npc_nxt;
            r_valid       <= w_valid_nxt;
            r_hlt         <= w_hlt_nxt;
            r_stall_count <= w_stall_count_nxt;
        end
    end

    assign bus.out_instr   = r_instr;
    assign bus.out_PC      = r_pc;
    assign bus.out_nextPC  = r_npc;
    assign bus.out_valid   = r_valid;
    assign bus.out_hlt     = r_hlt;
    assign bus.stall_count = r_stall_count;
    assign bus.stall_pc    = w_stall_pc;
    assign bus.bubble      = w_bubble;
    assign bus.halted      = (r_state == ST_HALTED) && !rst;
endmodule

// File: tb/tb_fetch_decode_hazard.sv
// Self-checking bench for fetch_decode_hazard: directed vector table,
// hand-written halt / reset / saturation sequences, and a randomized run
// against a behavioural reference model.
module tb_fetch_decode_hazard;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          NV  = 15;
    localparam int          NRAND = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fetch_decode_hazard_if bif();

    fetch_decode_hazard dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rs;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        hl;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        mem;
        logic        rw;
        logic [4:0]  wr;
        logic        rd;
        logic        e_stall;
        logic        e_bubble;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        logic        e_valid;
        logic        e_hlt;
        logic        e_halted;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic rs, input logic [31:0] ins, input logic [31:0] pc, input logic hl,
        input logic [4:0] r1, input logic [4:0] r2, input logic mem, input logic rw,
        input logic [4:0] wr, input logic rd, input logic es, input logic eb,
        input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] en,
        input logic ev, input logic eh, input logic ehd, input logic [15:0] ec);
        vec_t v;
        v.rs = rs; v.ins = ins; v.pc = pc; v.hl = hl; v.r1 = r1; v.r2 = r2;
        v.mem = mem; v.rw = rw; v.wr = wr; v.rd = rd; v.e_stall = es; v.e_bubble = eb;
        v.e_instr = ei; v.e_pc = ep; v.e_npc = en; v.e_valid = ev; v.e_hlt = eh;
        v.e_halted = ehd; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic rs, input logic [31:0] ins, input logic [31:0] pc,
                          input logic hl, input logic [4:0] r1, input logic [4:0] r2,
                          input logic mem, input logic rw, input logic [4:0] wr, input logic rd);
        rst                = rs;
        bif.in_instr       = ins;
        bif.in_PC          = pc;
        bif.in_nextPC      = pc + 32'd4;
        bif.in_hlt         = hl;
        bif.dec_read_reg1  = r1;
        bif.dec_read_reg2  = r2;
        bif.ex_mem_reg     = mem;
        bif.ex_reg_write   = rw;
        bif.ex_write_reg   = wr;
        bif.ex_redirect    = rd;
    endtask

    task automatic quiet(input logic [31:0] ins, input logic [31:0] pc);
        set_in(1'b0, ins, pc, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        edge1();
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_npc = 32'h0;
    bit          m_valid = 1'b0;
    bit          m_hlt = 1'b0;
    bit          m_halted = 1'b0;
    int          m_cnt = 0;

    function automatic bit m_load_use();
        return m_valid && bif.ex_mem_reg && bif.ex_reg_write && (bif.ex_write_reg != 5'd0) &&
               (bif.ex_write_reg == bif.dec_read_reg1 || bif.ex_write_reg == bif.dec_read_reg2);
    endfunction

    // Which event wins this cycle: 0 reset, 1 halted, 2 flush, 3 halt entry, 4 stall, 5 load
    function automatic int m_event();
        if (rst)                 return 0;
        if (m_halted)            return 1;
        if (bif.ex_redirect)     return 2;
        if (m_valid && m_hlt)    return 3;
        if (m_load_use())        return 4;
        return 5;
    endfunction

    function automatic void m_step();
        case (m_event())
            0: begin
                m_instr = NOP; m_pc = 0; m_npc = 0; m_valid = 0; m_hlt = 0;
                m_halted = 0; m_cnt = 0;
            end
            2: begin m_instr = NOP; m_valid = 0; m_hlt = 0; end
            3: m_halted = 1'b1;
            4: m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            5: begin
                m_instr = bif.in_instr; m_pc = bif.in_PC; m_npc = bif.in_nextPC;
                m_hlt = bif.in_hlt; m_valid = 1'b1;
            end
            default: ;
        endcase
    endfunction

    task automatic rnd_cycle(input int n);
        int   ev;
        logic [31:0] pc;
        pc = $urandom;
        set_in(($urandom_range(0, 19) == 0), $urandom, pc, ($urandom_range(0, 5) == 0),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        #1;
        ev = m_event();
        chk1($sformatf("rnd%0d stall_pc", n), bif.stall_pc, (ev == 1 || ev == 3 || ev == 4));
        chk1($sformatf("rnd%0d bubble", n), bif.bubble, (ev != 5) || !m_valid);
        chk1($sformatf("rnd%0d halted", n), bif.halted, m_halted && !rst);
        @(posedge clk);
        m_step();
        #1;
        chk($sformatf("rnd%0d out_instr", n), bif.out_instr, m_instr);
        chk($sformatf("rnd%0d out_PC", n), bif.out_PC, m_pc);
        chk($sformatf("rnd%0d out_nextPC", n), bif.out_nextPC, m_npc);
        chk1($sformatf("rnd%0d out_valid", n), bif.out_valid, m_valid);
        chk1($sformatf("rnd%0d out_hlt", n), bif.out_hlt, m_hlt);
        chk($sformatf("rnd%0d stall_count", n), 32'(bif.stall_count), 32'(m_cnt));
    endtask

    initial begin
        // rs, instr, pc, hlt, r1, r2, mem, rw, wr, redir | stall, bubble | instr, pc, npc, valid, hlt, halted, cnt
        vecs[0]  = mk(1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
                      NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[1]  = mk(1'b0, 32'h00500093, 32'h10, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
                      32'h00500093, 32'h10, 32'h14, 1'b1, 1'b0, 1'b0, 16'd0);
        vecs[2]  = mk(1'b0, 32'h00a00113, 32'h14, 1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1,
                      32'h00500093, 32'h10, 32'h14, 1'b1, 1'b0, 1'b0, 16'd1);
        vecs[3]  = mk(1'b0, 32'h00a00113, 32'h14, 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0,
                      32'h00a00113, 32'h14, 32'h18, 1'b1, 1'b0, 1'b0, 16'd1);
        vecs[4]  = mk(1'b0, 32'h00000193, 32'h18, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0,
                      32'h00000193, 32'h18, 32'h1c, 1'b1, 1'b0, 1'b0, 16'd1);
        vecs[5]  = mk(1'b0, 32'h12345678, 32'h1c, 1'b0, 5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1,
                      NOP, 32'h18, 32'h1c, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[6]  = mk(1'b0, 32'h00700233, 32'h40, 1'b0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1,
                      32'h00700233, 32'h40, 32'h44, 1'b1, 1'b0, 1'b0, 16'd1);
        vecs[7]  = mk(1'b0, 32'hfc000073, 32'h44, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                      32'hfc000073, 32'h44, 32'h48, 1'b1, 1'b1, 1'b0, 16'd1);
        vecs[8]  = mk(1'b0, 32'hdeadbeef, 32'h48, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1,
                      32'hfc000073, 32'h44, 32'h48, 1'b1, 1'b1, 1'b1, 16'd1);
        vecs[9]  = mk(1'b0, 32'hcafef00d, 32'h4c, 1'b0, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1,
                      32'hfc000073, 32'h44, 32'h48, 1'b1, 1'b1, 1'b1, 16'd1);
        vecs[10] = mk(1'b1, 32'h11111111, 32'h50, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
                      NOP, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
        vecs[11] = mk(1'b0, 32'h00100093, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
                      32'h00100093, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 16'd0);
        vecs[12] = mk(1'b0, 32'h00200113, 32'h4, 1'b0, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0,
                      32'h00200113, 32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 16'd0);
        vecs[13] = mk(1'b0, 32'h00300193, 32'h8, 1'b0, 5'd6, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1,
                      32'h00200113, 32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 16'd1);
        vecs[14] = mk(1'b0, 32'h00300193, 32'h8, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
                      32'h00300193, 32'h8, 32'hc, 1'b1, 1'b0, 1'b0, 16'd1);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].rs, vecs[i].ins, vecs[i].pc, vecs[i].hl, vecs[i].r1, vecs[i].r2,
                   vecs[i].mem, vecs[i].rw, vecs[i].wr, vecs[i].rd);
            #1;
            chk1($sformatf("v%0d stall_pc", i), bif.stall_pc, vecs[i].e_stall);
            chk1($sformatf("v%0d bubble", i), bif.bubble, vecs[i].e_bubble);
            edge1();
            chk($sformatf("v%0d out_instr", i), bif.out_instr, vecs[i].e_instr);
            chk($sformatf("v%0d out_PC", i), bif.out_PC, vecs[i].e_pc);
            chk($sformatf("v%0d out_nextPC", i), bif.out_nextPC, vecs[i].e_npc);
            chk1($sformatf("v%0d out_valid", i), bif.out_valid, vecs[i].e_valid);
            chk1($sformatf("v%0d out_hlt", i), bif.out_hlt, vecs[i].e_hlt);
            chk1($sformatf("v%0d halted", i), bif.halted, vecs[i].e_halted);
            chk($sformatf("v%0d stall_count", i), 32'(bif.stall_count), 32'(vecs[i].e_cnt));
        end

        // Halt: enters HALTED, ignores toggling inputs, leaves only via reset
        do_reset();
        set_in(1'b0, 32'h00100073, 32'h80, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        edge1();
        chk1("halt out_hlt", bif.out_hlt, 1'b1);
        chk1("halt pre halted", bif.halted, 1'b0);
        edge1();
        chk1("halt halted", bif.halted, 1'b1);
        chk1("halt stall_pc", bif.stall_pc, 1'b1);
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, (i % 2 == 0) ? 32'hffffffff : 32'h0, (i % 2 == 0) ? 32'hfffffff0 : 32'h100,
                   1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'(i % 2));
            edge1();
            chk($sformatf("halt%0d out_instr", i), bif.out_instr, 32'h00100073);
            chk($sformatf("halt%0d out_PC", i), bif.out_PC, 32'h80);
            chk($sformatf("halt%0d out_nextPC", i), bif.out_nextPC, 32'h84);
            chk1($sformatf("halt%0d halted", i), bif.halted, 1'b1);
            chk1($sformatf("halt%0d bubble", i), bif.bubble, 1'b1);
        end
        set_in(1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        chk1("halt rst halted", bif.halted, 1'b0);
        chk1("halt rst stall_pc", bif.stall_pc, 1'b0);
        chk1("halt rst bubble", bif.bubble, 1'b1);
        edge1();
        quiet(32'h0, 32'h0);
        #1;
        chk("halt rst out_instr", bif.out_instr, NOP);
        chk("halt rst out_PC", bif.out_PC, 32'h0);
        chk1("halt rst out_valid", bif.out_valid, 1'b0);
        chk1("halt after rst halted", bif.halted, 1'b0);
        chk1("halt after rst stall_pc", bif.stall_pc, 1'b0);

        // Reset while a load-use stall is active
        do_reset();
        quiet(32'h00500093, 32'h10);
        edge1();
        set_in(1'b0, 32'h00a00113, 32'h14, 1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
        #1;
        chk1("midrst stall_pc", bif.stall_pc, 1'b1);
        edge1();
        chk("midrst cnt", 32'(bif.stall_count), 32'd1);
        set_in(1'b1, 32'h00a00113, 32'h14, 1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0);
        #1;
        chk1("midrst rst stall_pc", bif.stall_pc, 1'b0);
        chk1("midrst rst bubble", bif.bubble, 1'b1);
        edge1();
        chk("midrst out_instr", bif.out_instr, NOP);
        chk("midrst out_PC", bif.out_PC, 32'h0);
        chk("midrst out_nextPC", bif.out_nextPC, 32'h0);
        chk1("midrst out_valid", bif.out_valid, 1'b0);
        chk1("midrst out_hlt", bif.out_hlt, 1'b0);
        chk("midrst cnt0", 32'(bif.stall_count), 32'd0);

        // Randomized run against the reference model
        do_reset();
        m_instr = NOP; m_pc = 0; m_npc = 0; m_valid = 0; m_hlt = 0; m_halted = 0; m_cnt = 0;
        for (int n = 0; n < NRAND; n++) begin
            rnd_cycle(n);
        end

        // Stall counter saturation over 65,537 consecutive hazard cycles
        do_reset();
        quiet(32'h00500093, 32'h10);
        edge1();
        set_in(1'b0, 32'h00a00113, 32'h14, 1'b0, 5'd9, 5'd1, 1'b1, 1'b1, 5'd9, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat cnt 65534", 32'(bif.stall_count), 32'h0000fffe);
        chk("sat held instr", bif.out_instr, 32'h00500093);
        edge1();
        chk("sat cnt 65535", 32'(bif.stall_count), 32'h0000ffff);
        edge1();
        edge1();
        chk("sat cnt hold", 32'(bif.stall_count), 32'h0000ffff);
        chk1("sat stall_pc", bif.stall_pc, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_decode_hazard.md
FETCH_DECODE_HAZARD -- requirements
Module: fetch_decode_hazard

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; every register updates only on the rising edge of clk.
REQ-002 SHALL have port `clk`, input, 1 bit: system clock.
REQ-003 SHALL have port `rst`, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port `in_instr`, input, 32 bits: instruction from instruction memory.
REQ-005 SHALL have ports `in_PC` and `in_nextPC`, inputs, 32 bits each: fetch PC and PC+4.
REQ-006 SHALL have port `in_hlt`, input, 1 bit: fetched instruction is hlt.
REQ-007 SHALL have ports `dec_read_reg1` and `dec_read_reg2`, inputs, 5 bits each: rs1/rs2 decoded from `out_instr`.
REQ-008 SHALL have ports `ex_mem_reg`, `ex_reg_write` (inputs, 1 bit each) and `ex_write_reg` (input, 5 bits): fetch/execute register outputs for the instruction now in execute.
REQ-009 SHALL have port `ex_redirect`, input, 1 bit: a taken branch, jal or jalr was resolved in execute this cycle.
REQ-010 SHALL have ports `out_instr`, `out_PC` and `out_nextPC`, outputs, 32 bits each: registered decode-stage instruction and PCs.
REQ-011 SHALL have ports `out_valid` and `out_hlt`, outputs, 1 bit each: decode slot holds a live instruction; that instruction is hlt.
REQ-012 SHALL have port `stall_pc`, output, 1 bit, combinational: PC register holds when high.
REQ-013 SHALL have port `bubble`, output, 1 bit, combinational: fetch/execute register must load all-zero control signals.
REQ-014 SHALL have port `halted`, output, 1 bit: FSM is in HALTED.
REQ-015 SHALL have port `stall_count`, output, 16 bits: saturating count of load-use stall cycles.

Function
REQ-016 SHALL implement an FSM with exactly two states, RUN and HALTED.
REQ-017 SHALL compute `hazard` = `out_valid` & `ex_mem_reg` & `ex_reg_write` & (`ex_write_reg` != 0) & ((`ex_write_reg` == `dec_read_reg1`) | (`ex_write_reg` == `dec_read_reg2`)).
REQ-018 SHALL, in RUN, resolve conflicts in this priority order: `ex_redirect`, then halt entry, then `hazard`, then normal load.
REQ-019 SHALL, in RUN with `ex_redirect` = 1 (flush), set next `out_instr` = 0x00000013, `out_valid` = 0 and `out_hlt` = 0, hold `out_PC`/`out_nextPC`, and drive `bubble` = 1 and `stall_pc` = 0.
REQ-020 SHALL, in RUN with `ex_redirect` = 0 and `out_valid` & `out_hlt` = 1, go to HALTED on the next edge, hold all pipeline registers, and drive `stall_pc` = 1 and `bubble` = 1.
REQ-021 SHALL, in RUN when `hazard` = 1 and no higher-priority event applies, hold all pipeline registers, drive `stall_pc` = 1 and `bubble` = 1, and increment `stall_count` by 1, saturating at 0xFFFF.
REQ-022 SHALL, in RUN with no higher-priority event, load `out_instr`/`out_PC`/`out_nextPC`/`out_hlt` from the inputs, set `out_valid` = 1, and drive `stall_pc` = 0 and `bubble` = !`out_valid` (current value).
REQ-023 SHALL, in HALTED, ignore every input except `rst`, hold all registers, and drive `stall_pc` = 1, `bubble` = 1 and `halted` = 1; HALTED is left only by reset.
REQ-024 SHALL suppress a hazard that coincides with `ex_redirect`: no stall and no `stall_count` increment.
REQ-025 SHALL treat a write to x0 as hazard-free, i.e. a load to x0 never stalls.
REQ-026 SHALL, on a hazard, stall for exactly one cycle per occurrence, because the load leaves execute as a bubble enters behind it.
REQ-027 SHALL add no latency of its own: an instruction loaded at edge N is visible on `out_*` after edge N.

Reset
REQ-028 SHALL, when `rst` = 1 at a clock edge, set `out_instr` = 0x00000013, `out_PC` = 0, `out_nextPC` = 0, `out_valid` = 0, `out_hlt` = 0, state = RUN and `stall_count` = 0, overriding all other inputs, including in HALTED or mid-stall.
REQ-029 SHALL, while `rst` = 1, drive `stall_pc` = 0, `bubble` = 1 and `halted` = 0.

Verification
REQ-030 SHALL be verified for normal flow: instr 0x00500093 at PC 0x10, no hazard -> next cycle `out_instr` = 0x00500093, `out_PC` = 0x10, `out_valid` = 1, `bubble` = 0.
REQ-031 SHALL be verified for load-use: `ex_mem_reg` = 1, `ex_reg_write` = 1, `ex_write_reg` = 5, `dec_read_reg2` = 5 -> `stall_pc` = 1 and `bubble` = 1 for one cycle, registers held, `stall_count` 0->1.
REQ-032 SHALL be verified for x0 and flush-over-hazard: `ex_write_reg` = 0 with a matching rs -> no stall; the same hazard with `ex_redirect` = 1 -> flush, `out_valid` = 0, `out_instr` = 0x00000013, `stall_count` unchanged.
REQ-033 SHALL be verified for halt: hlt loaded -> one cycle later `halted` = 1 and `stall_pc` = 1; PC and instruction inputs toggled for 10 cycles -> outputs unchanged; `rst` pulse -> RUN and reset values.
REQ-034 SHALL be verified for saturation: 65,537 consecutive hazard cycles -> `stall_count` = 0xFFFF and holds.
REQ-035 SHALL be verified for reset mid-stall: `rst` = 1 while `hazard` = 1 -> all outputs at reset values on the next edge, and `stall_count` = 0.
